// File: rtl/uart_tx_buffer_if.sv
// Byte-strobe side of the UART transmit buffer: the core writes bytes with a
// one-cycle strobe and watches the status flags. The core has no back-pressure.
interface uart_tx_buffer_if;
  logic       tx_ready;
  logic [7:0] sdata;
  logic       busy;
  logic       full;
  logic       overflow;

  // Core side: issues write strobes, observes status
  modport master (
    output tx_ready,
    output sdata,
    input  busy,
    input  full,
    input  overflow
  );

  // Buffer side: accepts or drops strobes, reports status
  modport slave (
    input  tx_ready,
    input  sdata,
    output busy,
    output full,
    output overflow
  );
endinterface

// File: rtl/uart_tx_buffer.sv
// UART transmitter with a small byte FIFO in front of it.
// Bytes arrive as one-cycle strobes and are either queued or dropped on the
// spot; a sticky overflow flag records any drop. The serializer sends 8N1
// frames LSB first and chains queued bytes back-to-back without an idle gap.
module uart_tx_buffer #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_buffer_if.slave  bus,
  output logic             txd
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;

  // The bit timer is sized for the largest legal bit period (4095 clocks).
  localparam logic [11:0] TIMER_LAST = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] TIMER_ONE  = 12'd1;

  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = 1;
  localparam logic [FIFO_DEPTH_LOG2:0]   COUNT_ONE  = 1;
  localparam logic [FIFO_DEPTH_LOG2:0]   COUNT_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wrPtr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rdPtr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic                       r_overflow;

  // Serializer state
  state_t     r_state;
  logic [11:0] r_timer;
  logic [2:0]  r_bitIdx;
  logic [7:0]  r_shift;
  logic        r_txd;

  logic       w_full;
  logic       w_notEmpty;
  logic       w_push;
  logic       w_drop;
  logic       w_pop;
  logic       w_bitDone;
  logic [7:0] w_headByte;

  // Occupancy is judged on the registered count, so a byte pushed this cycle
  // cannot be popped until the next one, and a full FIFO drops a strobe even
  // when a pop frees a slot on the same edge.
  assign w_full     = (r_count == COUNT_FULL);
  assign w_notEmpty = (r_count != '0);
  assign w_push     = bus.tx_ready && !w_full;
  assign w_drop     = bus.tx_ready && w_full;
  assign w_bitDone  = (r_timer == TIMER_LAST);
  assign w_headByte = r_mem[r_rdPtr];

  // The serializer takes a byte when idle, or on the final stop-bit cycle so
  // that queued frames follow each other with no idle gap.
  assign w_pop = w_notEmpty &&
                 ((r_state == IDLE) || ((r_state == STOP) && w_bitDone));

  // Store an accepted byte at the tail; reset suppresses writes
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wrPtr] <= bus.sdata;
    end
  end

  // Advance write/read pointers and keep the occupancy count in step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + COUNT_ONE;
        2'b01:   r_count <= r_count - COUNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Latch any dropped strobe until the next reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Frame serializer: start bit, eight data bits LSB first, stop bit, with
  // txd driven from a register so the line never glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_txd    <= 1'b1;
      r_timer  <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_txd    <= 1'b1;
          r_timer  <= '0;
          r_bitIdx <= '0;
          if (w_notEmpty) begin
            r_shift <= w_headByte;
            r_txd   <= 1'b0;
            r_state <= START;
          end
        end

        START: begin
          if (w_bitDone) begin
            r_timer  <= '0;
            r_bitIdx <= '0;
            r_txd    <= r_shift[0];
            r_state  <= DATA;
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end

        DATA: begin
          if (w_bitDone) begin
            r_timer <= '0;
            if (r_bitIdx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
              r_shift  <= {1'b0, r_shift[7:1]};
              r_txd    <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end

        STOP: begin
          if (w_bitDone) begin
            r_timer  <= '0;
            r_bitIdx <= '0;
            if (w_notEmpty) begin
              r_shift <= w_headByte;
              r_txd   <= 1'b0;
              r_state <= START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  assign txd          = r_txd;
  assign bus.busy     = (r_state != IDLE) || w_notEmpty;
  assign bus.full     = w_full;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer at 4 clocks per bit and an 8-deep FIFO.
// Stimulus pushes the expected byte of every accepted strobe into a queue; an
// independent line monitor decodes frames off txd and checks them in order.
module tb_uart_tx_buffer;

  localparam int CPB = 4;

  logic clk;
  logic rst;
  logic txd;

  uart_tx_buffer_if bus ();

  uart_tx_buffer #(
    .CLKS_PER_BIT    (CPB),
    .FIFO_DEPTH_LOG2 (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .txd (txd)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] expQ [$];
  bit sawFull;

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called 1 ns after an edge; the strobe is captured on the next edge and
  // the task returns 1 ns after that capturing edge.
  task automatic applyStimulus(input logic [7:0] b, input bit expectAccepted);
    bus.tx_ready = 1'b1;
    bus.sdata    = b;
    if (expectAccepted) expQ.push_back(b);
    @(posedge clk);
    #1;
    bus.tx_ready = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while (bus.busy && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", n >= maxCycles, 0);
    @(posedge clk);
    #1;
  endtask

  // Line pattern of one 8N1 frame, one entry per clock cycle
  function automatic logic [39:0] framePattern(input logic [7:0] b);
    logic [39:0] p;
    for (int k = 0; k < 40; k++) begin
      if (k < 4)       p[k] = 1'b0;
      else if (k < 36) p[k] = b[(k - 4) / 4];
      else             p[k] = 1'b1;
    end
    return p;
  endfunction

  // Line monitor: capture 40 cycles from each start bit, abandon on reset
  initial begin
    logic [39:0] rxPat;
    logic [7:0]  rxByte;
    logic [7:0]  expByte;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && txd === 1'b0) begin
        rxPat    = '0;
        rxPat[0] = txd;
        aborted  = 0;
        for (int k = 1; k < 40; k++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1;
            break;
          end
          rxPat[k] = txd;
        end
        if (!aborted) begin
          for (int i = 0; i < 8; i++) rxByte[i] = rxPat[4 * (i + 1) + 2];
          checkOutput("frame_expected", expQ.size() != 0, 1);
          if (expQ.size() != 0) begin
            expByte = expQ.pop_front();
            checkOutput("frame_byte", rxByte, expByte);
            checkOutput("frame_pattern", rxPat, framePattern(expByte));
          end
        end
      end
    end
  end

  // Global watchdog
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Directed stimulus
  initial begin
    rst          = 1'b1;
    bus.tx_ready = 1'b0;
    bus.sdata    = 8'h00;
    sawFull      = 0;

    // Reset, with a strobe issued during reset that must be ignored
    repeat (3) @(posedge clk);
    #1;
    bus.tx_ready = 1'b1;
    bus.sdata    = 8'hAA;
    @(posedge clk);
    #1;
    bus.tx_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_txd", txd, 1);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_full", bus.full, 0);
    checkOutput("reset_overflow", bus.overflow, 0);
    @(posedge clk);
    #1;
    checkOutput("reset_strobe_ignored", bus.busy, 0);

    // Single byte 0x55: latency and frame length
    applyStimulus(8'h55, 1);
    checkOutput("latency_before_start", txd, 1);
    checkOutput("busy_after_push", bus.busy, 1);
    @(posedge clk);
    #1;
    checkOutput("latency_start_bit", txd, 0);
    repeat (39) @(posedge clk);
    #1;
    checkOutput("single_busy_last_cycle", bus.busy, 1);
    @(posedge clk);
    #1;
    checkOutput("single_busy_fall", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back 0xA3, 0x0F: two frames with no gap
    applyStimulus(8'hA3, 1);
    applyStimulus(8'h0F, 1);
    repeat (79) @(posedge clk);
    #1;
    checkOutput("b2b_busy_last_cycle", bus.busy, 1);
    @(posedge clk);
    #1;
    checkOutput("b2b_busy_fall", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1;

    // Overflow: 0x00..0x09 consecutive, 0x09 dropped
    for (int i = 0; i < 10; i++) applyStimulus(8'(i), i < 9);
    checkOutput("ovf_full", bus.full, 1);
    checkOutput("ovf_flag", bus.overflow, 1);
    waitIdle(600);
    checkOutput("ovf_sticky", bus.overflow, 1);
    doReset();
    checkOutput("ovf_cleared_by_reset", bus.overflow, 0);

    // Full FIFO with a strobe landing on the same edge as a pop
    for (int i = 0; i < 9; i++) applyStimulus(8'h10 + 8'(i), 1);
    @(posedge clk);
    repeat (31) @(posedge clk);
    #1;
    checkOutput("fullpop_full_before", bus.full, 1);
    checkOutput("fullpop_ovf_before", bus.overflow, 0);
    applyStimulus(8'hEE, 0);
    checkOutput("fullpop_full_after", bus.full, 0);
    checkOutput("fullpop_ovf_after", bus.overflow, 1);
    waitIdle(600);

    // Reset during data bit 3 of 0xFF with three bytes queued
    applyStimulus(8'hFF, 0);
    applyStimulus(8'h01, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h03, 0);
    repeat (15) @(posedge clk);
    #1;
    checkOutput("midrst_txd_before", txd, 1);
    checkOutput("midrst_ovf_before", bus.overflow, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_txd", txd, 1);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_full", bus.full, 0);
    checkOutput("midrst_overflow", bus.overflow, 0);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("midrst_stays_idle", bus.busy, 0);

    // Pointer wrap: 20 bytes, one every 40 cycles
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'((i * 37 + 5) & 8'hFF), 1);
      repeat (39) begin
        @(posedge clk);
        #1;
        if (bus.full) sawFull = 1;
      end
    end
    waitIdle(200);
    checkOutput("wrap_full_never", sawFull, 0);
    checkOutput("wrap_overflow", bus.overflow, 0);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
